// File: rtl/ball_serve_ctrl.sv
// Ball serve controller: holds the ball at centre for a programmed number of
// frames after a score, then launches it with a velocity drawn from the LFSR.
module ball_serve_ctrl #(
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int SPEED              = 2,
  parameter int MAX_DY             = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_rand_in,
  input  logic       i_serve_req,
  input  logic       i_last_scorer,
  input  logic       i_frame_tick,
  output logic       o_serving,
  output logic       o_launch,
  output logic [3:0] o_vel_x,
  output logic [3:0] o_vel_y,
  output logic [7:0] o_serve_count
);
  // state  | meaning
  // IDLE   | ball at centre after reset, waiting for the first serve request
  // WAIT   | ball held at centre, frame counter running down
  // SAMPLE | one cycle; rand_in is mapped into the velocity at the exit edge
  // LAUNCH | one cycle; launch pulse with the new velocity
  // PLAY   | ball in motion, velocity held until the next serve request
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_PLAY   = 3'd4;

  localparam logic [7:0] DELAY_INIT = 8'(SERVE_DELAY_FRAMES);
  localparam logic [3:0] SPEED_POS  = 4'(SPEED);
  localparam logic [3:0] SPEED_NEG  = 4'(-SPEED);
  localparam logic [1:0] MAX_DY_L   = 2'(MAX_DY);

  logic [2:0] r_state;
  logic [7:0] r_count;
  logic       r_dir;
  logic       r_serving;
  logic       r_launch;
  logic [3:0] r_vel_x;
  logic [3:0] r_vel_y;
  logic [7:0] r_serve_count;

  logic [1:0] w_mag_raw;
  logic [1:0] w_mag;
  logic [3:0] w_vel_x_new;
  logic [3:0] w_vel_y_new;

  // A zero vertical component would make the ball bounce flat forever.
  always_comb begin
    w_mag_raw   = (i_rand_in[1:0] == 2'd0) ? 2'd1 : i_rand_in[1:0];
    w_mag       = (w_mag_raw > MAX_DY_L) ? MAX_DY_L : w_mag_raw;
    w_vel_y_new = i_rand_in[2] ? (4'd0 - {2'b00, w_mag}) : {2'b00, w_mag};
    w_vel_x_new = r_dir ? SPEED_POS : SPEED_NEG;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_count       <= 8'd0;
      r_dir         <= 1'b0;
      r_serving     <= 1'b1;
      r_launch      <= 1'b0;
      r_vel_x       <= 4'd0;
      r_vel_y       <= 4'd0;
      r_serve_count <= 8'd0;
    end else begin
      r_launch <= 1'b0;
      case (r_state)
        S_IDLE, S_PLAY: begin
          if (i_serve_req) begin
            r_state   <= S_WAIT;
            r_count   <= DELAY_INIT;
            r_dir     <= i_last_scorer;
            r_serving <= 1'b1;
            r_vel_x   <= 4'd0;
            r_vel_y   <= 4'd0;
          end
        end
        S_WAIT: begin
          // A fresh request restarts the hold and beats both exit and decrement.
          if (i_serve_req) begin
            r_count <= DELAY_INIT;
            r_dir   <= i_last_scorer;
          end else if (r_count == 8'd0) begin
            r_state <= S_SAMPLE;
          end else if (i_frame_tick) begin
            r_count <= r_count - 8'd1;
          end
        end
        S_SAMPLE: begin
          r_state   <= S_LAUNCH;
          r_launch  <= 1'b1;
          r_serving <= 1'b0;
          r_vel_x   <= w_vel_x_new;
          r_vel_y   <= w_vel_y_new;
        end
        S_LAUNCH: begin
          r_state       <= S_PLAY;
          r_serve_count <= r_serve_count + 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_serving     = r_serving;
  assign o_launch      = r_launch;
  assign o_vel_x       = r_vel_x;
  assign o_vel_y       = r_vel_y;
  assign o_serve_count = r_serve_count;
endmodule
